uart_tx_ctrl: RTL and testbench

Transmit-side controller that shares the single uart transmitter between two byte producers: port 0 (core MMIO store path) and port 1 (debug/trap message printer).
- Round-robin arbitration admits bytes into a shared FIFO.
- A pacing scheduler drains the FIFO into the uart's one-cycle wr_en/wr_data interface.
- Write strobes are never closer than one full frame apart, because the uart ignores wr_en while a frame is in flight.

---
 rtl/uart_tx_ctrl.sv | 135 +++++++++++++
 tb/tb_uart_tx_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_ctrl.sv
// Two-port transmit controller: round-robin admission into a byte FIFO, drained
// into the uart's single-cycle write strobe no faster than one frame per FRAME_CYCLES.
module uart_tx_ctrl #(
    parameter int FIFO_DEPTH_LOG2 = 4,
    parameter int FRAME_CYCLES    = 5209
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     s0_valid,
    input  logic [7:0]               s0_data,
    output logic                     s0_ready,
    input  logic                     s1_valid,
    input  logic [7:0]               s1_data,
    output logic                     s1_ready,
    input  logic                     tx_enable,
    input  logic                     flush,
    output logic                     uart_wr_en,
    output logic [7:0]               uart_wr_data,
    output logic [FIFO_DEPTH_LOG2:0] fifo_count,
    output logic                     busy
);
    localparam int DEPTH = 1 << FIFO_DEPTH_LOG2;
    localparam logic [FIFO_DEPTH_LOG2:0]   FULL_CNT = (FIFO_DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [FIFO_DEPTH_LOG2:0]   CNT_ONE  = (FIFO_DEPTH_LOG2 + 1)'(1);
    localparam logic [FIFO_DEPTH_LOG2-1:0] PTR_ONE  = FIFO_DEPTH_LOG2'(1);
    localparam logic [15:0]                FRAME_M1 = 16'(FRAME_CYCLES - 1);

    typedef enum logic {IDLE, WAIT} state_t;

    state_t                     state_q, state_d;
    logic [15:0]                pace_q, pace_d;
    logic [7:0]                 mem [DEPTH];
    logic [FIFO_DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic                       rr_last;
    logic                       full, can_push, grant0, grant1, push, pop;
    logic [7:0]                 push_data;
    logic                       wr_en_d;
    logic [7:0]                 wr_data_d;

    assign full     = (fifo_count == FULL_CNT);
    assign can_push = !full && !flush;

    // rr_last names the last granted port; on a tie the other one wins.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (can_push) begin
            if (s0_valid && (!s1_valid || rr_last))
                grant0 = 1'b1;
            else if (s1_valid)
                grant1 = 1'b1;
        end
    end

    assign s0_ready  = grant0;
    assign s1_ready  = grant1;
    assign push      = grant0 | grant1;
    assign push_data = grant0 ? s0_data : s1_data;

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            rr_last    <= 1'b1;
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr  <= wr_ptr + PTR_ONE;
                rr_last <= grant1;
            end
            if (pop)
                rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + CNT_ONE;
                2'b01:   fifo_count <= fifo_count - CNT_ONE;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Launch on a flush cycle is suppressed so a discarded byte never reaches the uart.
    always_comb begin
        state_d   = state_q;
        pace_d    = pace_q;
        wr_en_d   = 1'b0;
        wr_data_d = uart_wr_data;
        pop       = 1'b0;
        case (state_q)
            IDLE: begin
                if (fifo_count != '0 && tx_enable && !flush) begin
                    pop       = 1'b1;
                    wr_en_d   = 1'b1;
                    wr_data_d = mem[rd_ptr];
                    pace_d    = FRAME_M1;
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (pace_q <= 16'd1) begin
                    pace_d  = 16'd0;
                    state_d = IDLE;
                end else begin
                    pace_d = pace_q - 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pace_q       <= 16'd0;
            uart_wr_en   <= 1'b0;
            uart_wr_data <= 8'h00;
        end else begin
            state_q      <= state_d;
            pace_q       <= pace_d;
            uart_wr_en   <= wr_en_d;
            uart_wr_data <= wr_data_d;
        end
    end

    assign busy = (state_q == WAIT) | (fifo_count != '0) | uart_wr_en;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl: a FRAME_CYCLES=20 instance for the main scenarios
// and a FRAME_CYCLES=2 instance for the minimum-spacing boundary.
module tb_uart_tx_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;

    logic       s0_valid, s1_valid, s0_ready, s1_ready, tx_enable, flush, wr_en, busy;
    logic [7:0] s0_data, s1_data, wr_data;
    logic [2:0] count;

    logic       b_s0_valid, b_s1_valid, b_s0_ready, b_s1_ready, b_tx_enable, b_flush, b_wr_en, b_busy;
    logic [7:0] b_s0_data, b_s1_data, b_wr_data;
    logic [2:0] b_count;

    int ncmp = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    uart_tx_ctrl #(.FIFO_DEPTH_LOG2(2), .FRAME_CYCLES(20)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .s0_valid(s0_valid), .s0_data(s0_data), .s0_ready(s0_ready),
        .s1_valid(s1_valid), .s1_data(s1_data), .s1_ready(s1_ready),
        .tx_enable(tx_enable), .flush(flush),
        .uart_wr_en(wr_en), .uart_wr_data(wr_data),
        .fifo_count(count), .busy(busy)
    );

    uart_tx_ctrl #(.FIFO_DEPTH_LOG2(2), .FRAME_CYCLES(2)) u_dut_fast (
        .clk(clk), .rst_n(rst_n),
        .s0_valid(b_s0_valid), .s0_data(b_s0_data), .s0_ready(b_s0_ready),
        .s1_valid(b_s1_valid), .s1_data(b_s1_data), .s1_ready(b_s1_ready),
        .tx_enable(b_tx_enable), .flush(b_flush),
        .uart_wr_en(b_wr_en), .uart_wr_data(b_wr_data),
        .fifo_count(b_count), .busy(b_busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        s0_valid = 1'b0;
        s1_valid = 1'b0;
        flush    = 1'b0;
        rst_n    = 1'b0;
        cyc();
        rst_n    = 1'b1;
    endtask

    logic [7:0] acc_q [$];
    logic [7:0] str_d [$];
    int         str_t [$];
    logic [7:0] n0, n1, d;
    logic [7:0] exp2 [4];
    int         acc, pulses;

    initial begin
        exp2 = '{8'h10, 8'h20, 8'h11, 8'h21};
        rst_n = 1'b0;
        s0_valid = 1'b0; s1_valid = 1'b0; s0_data = 8'h00; s1_data = 8'h00;
        tx_enable = 1'b0; flush = 1'b0;
        b_s0_valid = 1'b0; b_s1_valid = 1'b0; b_s0_data = 8'h00; b_s1_data = 8'h00;
        b_tx_enable = 1'b0; b_flush = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // reset state
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_data", wr_data, 8'h00);
        chk("rst_count", count, 0);
        chk("rst_busy", busy, 0);
        rst_n = 1'b1;
        tx_enable = 1'b1;

        // single byte: ready now, strobe two cycles later, busy drops 20 edges after acceptance
        cyc(); s0_valid = 1'b1; s0_data = 8'h41; #1;
        chk("t1_s0_ready", s0_ready, 1);
        cyc(); s0_valid = 1'b0; #1;
        chk("t1_count_after_push", count, 1);
        chk("t1_no_early_strobe", wr_en, 0);
        cyc(); #1;
        chk("t1_strobe", wr_en, 1);
        chk("t1_strobe_data", wr_data, 8'h41);
        chk("t1_count_after_pop", count, 0);
        chk("t1_busy_wait", busy, 1);
        cyc(); #1;
        chk("t1_single_pulse", wr_en, 0);
        repeat (17) cyc();
        #1;
        chk("t1_busy_before_end", busy, 1);
        cyc(); #1;
        chk("t1_busy_fall", busy, 0);

        // round-robin with both ports always offering
        do_reset();
        n0 = 8'h00; n1 = 8'h00;
        for (int c = 0; c < 100; c++) begin
            cyc();
            s0_valid = (acc_q.size() < 4) ? 1'b1 : 1'b0;
            s1_valid = (acc_q.size() < 4) ? 1'b1 : 1'b0;
            s0_data  = 8'h10 + n0;
            s1_data  = 8'h20 + n1;
            #1;
            if (c == 0) begin
                chk("t2_tie_s0_first", s0_ready, 1);
                chk("t2_tie_s1_waits", s1_ready, 0);
            end
            if (s0_ready && s1_ready) chk("t2_double_grant", 1, 0);
            if (s0_ready) begin acc_q.push_back(s0_data); n0++; end
            if (s1_ready) begin acc_q.push_back(s1_data); n1++; end
            if (wr_en) begin str_d.push_back(wr_data); str_t.push_back(c); end
        end
        s0_valid = 1'b0; s1_valid = 1'b0;
        chk("t2_accepted", acc_q.size(), 4);
        for (int i = 0; i < acc_q.size() && i < 4; i++) chk("t2_accept_order", acc_q[i], exp2[i]);
        chk("t2_strobes", str_t.size(), 4);
        if (str_t.size() > 0) chk("t2_first_strobe_cycle", str_t[0], 2);
        for (int i = 0; i < str_d.size() && i < 4; i++) chk("t2_uart_order", str_d[i], exp2[i]);
        for (int i = 1; i < str_t.size(); i++) chk("t2_spacing", str_t[i] - str_t[i-1], 20);
        chk("t2_idle_busy", busy, 0);

        // fill with tx disabled, then pop frees one slot for one push
        tx_enable = 1'b0;
        acc = 0; d = 8'h30;
        for (int k = 0; k < 8; k++) begin
            cyc(); s0_valid = 1'b1; s0_data = d; #1;
            if (s0_ready) begin acc++; d++; end
        end
        chk("t3_accepted", acc, 4);
        chk("t3_full_ready", s0_ready, 0);
        chk("t3_full_count", count, 4);
        chk("t3_no_strobe_disabled", wr_en, 0);
        cyc(); tx_enable = 1'b1; #1;
        chk("t3_prepop_ready", s0_ready, 0);
        cyc(); #1;
        chk("t3_strobe", wr_en, 1);
        chk("t3_strobe_data", wr_data, 8'h30);
        chk("t3_count_after_pop", count, 3);
        chk("t3_ready_after_pop", s0_ready, 1);
        cyc(); #1;
        chk("t3_refilled_count", count, 4);
        chk("t3_refilled_ready", s0_ready, 0);
        s0_valid = 1'b0;

        // flush during WAIT
        do_reset();
        tx_enable = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc(); s0_valid = 1'b1; s0_data = 8'h50 + 8'(k);
        end
        cyc(); s0_valid = 1'b0; #1;
        chk("t4_count_pre_flush", count, 2);
        cyc(); flush = 1'b1;
        cyc(); flush = 1'b0; #1;
        chk("t4_flush_count", count, 0);
        chk("t4_busy_in_wait", busy, 1);
        pulses = 0;
        repeat (15) begin cyc(); pulses += int'(wr_en); end
        #1;
        chk("t4_busy_before_expiry", busy, 1);
        cyc(); #1;
        chk("t4_busy_after_expiry", busy, 0);
        repeat (10) begin cyc(); pulses += int'(wr_en); end
        chk("t4_no_strobe_after_flush", pulses, 0);

        // asynchronous reset while a strobe is out and bytes are queued
        tx_enable = 1'b0;
        for (int k = 0; k < 3; k++) begin
            cyc(); s0_valid = 1'b1; s0_data = 8'h60 + 8'(k);
        end
        cyc(); s0_valid = 1'b0; #1;
        chk("t5_queued", count, 3);
        cyc(); tx_enable = 1'b1;
        cyc(); #1;
        chk("t5_strobe", wr_en, 1);
        chk("t5_strobe_data", wr_data, 8'h60);
        chk("t5_count", count, 2);
        rst_n = 1'b0; #1;
        chk("t5_async_wr_en", wr_en, 0);
        chk("t5_async_wr_data", wr_data, 8'h00);
        chk("t5_async_count", count, 0);
        chk("t5_async_busy", busy, 0);
        cyc(); rst_n = 1'b1;
        s0_valid = 1'b1; s1_valid = 1'b1; s0_data = 8'h80; s1_data = 8'h90; #1;
        chk("t5_tie_s0_after_reset", s0_ready, 1);
        chk("t5_tie_s1_after_reset", s1_ready, 0);
        cyc(); s0_data = 8'h81; #1;
        chk("t5_tie_alternates_s0", s0_ready, 0);
        chk("t5_tie_alternates_s1", s1_ready, 1);
        cyc(); s0_valid = 1'b0; s1_valid = 1'b0;

        // FRAME_CYCLES=2: strobes every other cycle
        str_d.delete(); str_t.delete();
        for (int k = 0; k < 3; k++) begin
            cyc(); b_s0_valid = 1'b1; b_s0_data = 8'h70 + 8'(k);
        end
        cyc(); b_s0_valid = 1'b0; #1;
        chk("t6_backlog", b_count, 3);
        cyc(); b_tx_enable = 1'b1; #1;
        chk("t6_no_strobe_yet", b_wr_en, 0);
        for (int c = 1; c < 12; c++) begin
            cyc(); #1;
            if (b_wr_en) begin str_d.push_back(b_wr_data); str_t.push_back(c); end
        end
        chk("t6_strobes", str_t.size(), 3);
        for (int i = 0; i < str_t.size() && i < 3; i++) begin
            chk("t6_strobe_cycle", str_t[i], 1 + 2 * i);
            chk("t6_strobe_data", str_d[i], 8'h70 + 8'(i));
        end
        chk("t6_drained_busy", b_busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
